// File: rtl/apuf_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : apuf_pkg                                                     |
// | Description : Shared types and helpers for the arbiter-PUF challenge       |
// |               sequencer: FSM state encoding, LFSR tap lookup by width and  |
// |               the challenge-stepping function.                             |
// | Contents    : apuf_state_e, c_LFSR_MAX_W, lfsr_tap(), lfsr_next()          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package apuf_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      LAUNCH = 3'd2,
      SAMPLE = 3'd3,
      DISCH  = 3'd4,
      DONE   = 3'd5
   } apuf_state_e;

   // Widest challenge the generic LFSR helper supports.
   localparam int unsigned c_LFSR_MAX_W = 64;

   // Second feedback tap (bit index) for a Fibonacci LFSR of the given width,
   // polynomial x^W + x^(TAP+1) + 1. Legal widths are 2..c_LFSR_MAX_W.
   // Widths without a table entry fall back to x^W + x^(W-1) + 1, which is
   // not guaranteed to be maximal length.
   function automatic int unsigned lfsr_tap(input int unsigned width);
      case (width)
         2:       return 0;
         3:       return 1;
         4:       return 2;
         5:       return 2;
         6:       return 4;
         7:       return 5;
         15:      return 13;
         22:      return 20;
         23:      return 17;
         28:      return 24;
         31:      return 27;
         default: return width - 2;
      endcase
   endfunction

   // One left-shift step: new LSB = chal[W-1] ^ chal[TAP]. Bits at and above
   // the active width are forced to zero so the caller can simply truncate.
   function automatic logic [c_LFSR_MAX_W-1:0] lfsr_next(
      input logic [c_LFSR_MAX_W-1:0] chal,
      input int unsigned             width
   );
      logic [c_LFSR_MAX_W-1:0] mask;
      logic [5:0]              msb;
      logic [5:0]              tap;
      logic                    fb;
      msb  = 6'(width - 1);
      tap  = 6'(lfsr_tap(width));
      fb   = chal[msb] ^ chal[tap];
      mask = (width >= c_LFSR_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
      return ((chal << 1) & mask) | {63'd0, fb};
   endfunction

endpackage : apuf_pkg

`default_nettype wire

// File: rtl/apuf_challenge_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | Interface   : apuf_challenge_sequencer_if                                  |
// | Description : Seed and response valid/ready channels between the host     |
// |               and the arbiter-PUF challenge sequencer.                     |
// | Signals     : seed_valid/seed_ready/seed_chal  host -> sequencer seed      |
// |               resp_valid/resp_ready/resp_data  sequencer -> host response  |
// | Modports    : master (host side), slave (sequencer side)                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface apuf_challenge_sequencer_if #(
   parameter int CHAL_W    = 22,
   parameter int RESP_BITS = 32
);
   logic                 seed_valid;
   logic                 seed_ready;
   logic [CHAL_W-1:0]    seed_chal;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [RESP_BITS-1:0] resp_data;

   modport master (
      output seed_valid, seed_chal, resp_ready,
      input  seed_ready, resp_valid, resp_data
   );

   modport slave (
      input  seed_valid, seed_chal, resp_ready,
      output seed_ready, resp_valid, resp_data
   );
endinterface : apuf_challenge_sequencer_if

`default_nettype wire

// File: rtl/bit_sync2.sv
// +----------------------------------------------------------------------------+
// | Module      : bit_sync2                                                    |
// | Description : Two-flop synchronizer for a single asynchronous bit, with    |
// |               synchronous active-high reset to 0.                          |
// | Ports       : clk  in  system clock                                        |
// |               rst  in  synchronous reset                                   |
// |               d_i  in  asynchronous input                                  |
// |               q_o  out synchronized output (2 cycles latency)              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module bit_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule : bit_sync2

`default_nettype wire

// File: rtl/apuf_challenge_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : apuf_challenge_sequencer                                     |
// | Description : Drives one arbiter-PUF. Accepts a seed challenge, walks an   |
// |               LFSR through RESP_BITS challenges, fires the X/Y race for    |
// |               each, samples the synchronized arbiter output and returns    |
// |               the packed response word over a valid/ready channel.         |
// | Ports       : clk, rst       clock, synchronous active-high reset          |
// |               bus (slave)    seed_* in, resp_* out handshake channels      |
// |               puf_chal_o     challenge to the APUF                         |
// |               puf_x_o/y_o    race launch (always equal)                    |
// |               puf_q_i        APUF arbiter output, asynchronous             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module apuf_challenge_sequencer
   import apuf_pkg::*;
#(
   parameter int CHAL_W        = 22,
   parameter int RESP_BITS     = 32,
   parameter int SETTLE_CYCLES = 8,   // >= 3 so the sync has settled
   parameter int DISCH_CYCLES  = 4    // >= 1
) (
   input  logic                      clk,
   input  logic                      rst,
   apuf_challenge_sequencer_if.slave bus,
   output logic [CHAL_W-1:0]         puf_chal_o,
   output logic                      puf_x_o,
   output logic                      puf_y_o,
   input  logic                      puf_q_i
);

   localparam int c_CNT_MAX = (SETTLE_CYCLES > DISCH_CYCLES) ? SETTLE_CYCLES : DISCH_CYCLES;
   localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
   localparam int c_BIT_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_DISCH_LAST  = c_CNT_W'(DISCH_CYCLES - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST    = c_BIT_W'(RESP_BITS - 1);

   apuf_state_e          state_q,      state_d;
   logic [c_CNT_W-1:0]   cnt_q,        cnt_d;
   logic [c_BIT_W-1:0]   bit_cnt_q,    bit_cnt_d;
   logic [CHAL_W-1:0]    puf_chal_q,   puf_chal_d;
   logic [RESP_BITS-1:0] resp_data_q,  resp_data_d;
   logic                 x_q,          x_d;
   logic                 seed_ready_q, seed_ready_d;
   logic                 resp_valid_q, resp_valid_d;

   logic                 q_sync;
   logic [CHAL_W-1:0]    lfsr_step;

   bit_sync2 u_q_sync (
      .clk (clk),
      .rst (rst),
      .d_i (puf_q_i),
      .q_o (q_sync)
   );

   assign lfsr_step = CHAL_W'(lfsr_next(c_LFSR_MAX_W'(puf_chal_q), CHAL_W));

   // -------------------------------------------------------------------------
   // Next-state and datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      puf_chal_d   = puf_chal_q;
      resp_data_d  = resp_data_q;
      x_d          = 1'b0;
      seed_ready_d = 1'b0;
      resp_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            // The seed is captured on the accepting edge so the host may drop
            // seed_chal immediately; an all-zero seed would lock the LFSR.
            if (bus.seed_valid && seed_ready_q) begin
               state_d     = LOAD;
               puf_chal_d  = (bus.seed_chal == '0) ? CHAL_W'(1) : bus.seed_chal;
               bit_cnt_d   = '0;
               cnt_d       = '0;
               resp_data_d = '0;
            end
         end

         LOAD: begin
            state_d = LAUNCH;
            cnt_d   = '0;
         end

         LAUNCH: begin
            if (cnt_q == c_SETTLE_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end

         SAMPLE: begin
            resp_data_d[bit_cnt_q] = q_sync;
            state_d                = DISCH;
            cnt_d                  = '0;
         end

         DISCH: begin
            // The challenge only steps here, on the same edge that relaunches
            // X/Y, so it is never modified while a race is in flight.
            if (cnt_q == c_DISCH_LAST) begin
               cnt_d      = '0;
               puf_chal_d = lfsr_step;
               if (bit_cnt_q == c_BIT_LAST) begin
                  state_d = DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
                  state_d   = LAUNCH;
               end
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end

         DONE: begin
            if (bus.resp_ready && resp_valid_q) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered outputs are decoded from the next state so they line up
      // with state_q, yet stay 0 throughout reset.
      x_d          = (state_d == LAUNCH) || (state_d == SAMPLE);
      seed_ready_d = (state_d == IDLE);
      resp_valid_d = (state_d == DONE);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         puf_chal_q   <= '0;
         resp_data_q  <= '0;
         x_q          <= 1'b0;
         seed_ready_q <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         puf_chal_q   <= puf_chal_d;
         resp_data_q  <= resp_data_d;
         x_q          <= x_d;
         seed_ready_q <= seed_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign bus.seed_ready = seed_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign puf_chal_o     = puf_chal_q;
   assign puf_x_o        = x_q;
   assign puf_y_o        = x_q;

endmodule : apuf_challenge_sequencer

`default_nettype wire

// File: tb/tb_apuf_challenge_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_apuf_challenge_sequencer                                  |
// | Description : Self-checking bench for apuf_challenge_sequencer. A model    |
// |               APUF (parity of masked challenge bits) drives puf_q; the     |
// |               expected challenges and responses are queued at each seed    |
// |               acceptance and compared by an independent monitor.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_apuf_challenge_sequencer;

   localparam int CW       = 22;
   localparam int RB       = 4;
   localparam int ST       = 4;
   localparam int DC       = 2;
   localparam int BIT_TIME = ST + 1 + DC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] puf_chal;
   logic          puf_x;
   logic          puf_y;
   logic          puf_q;
   logic [CW-1:0] puf_mask = '1;

   apuf_challenge_sequencer_if #(.CHAL_W(CW), .RESP_BITS(RB)) bus ();

   apuf_challenge_sequencer #(
      .CHAL_W        (CW),
      .RESP_BITS     (RB),
      .SETTLE_CYCLES (ST),
      .DISCH_CYCLES  (DC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .puf_chal_o (puf_chal),
      .puf_x_o    (puf_x),
      .puf_y_o    (puf_y),
      .puf_q_i    (puf_q)
   );

   // Behavioural APUF: response = parity of the challenge bits selected by mask.
   assign puf_q = (($countones(puf_chal & puf_mask) % 2) == 1);

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {logic [RB-1:0] data; int k;} resp_t;
   typedef struct {logic [CW-1:0] chal; int idx;} chal_t;
   resp_t exp_resp[$];
   chal_t exp_chal[$];
   int    hs_edge    = -1;
   int    resp_seen  = 0;
   int    resp_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Next challenge by arithmetic: double mod 2^22, plus XOR of bits 21 and 20.
   function automatic logic [CW-1:0] ref_next(input logic [CW-1:0] c);
      int unsigned v;
      int unsigned fb;
      v  = c;
      fb = ((v >> 21) ^ (v >> 20)) & 1;
      return CW'(((v * 2) % (1 << 22)) + fb);
   endfunction

   task automatic push_model(input logic [CW-1:0] seed, input int k);
      logic [CW-1:0] c;
      resp_t         r;
      chal_t         e;
      c      = (seed == '0) ? CW'(1) : seed;
      r.data = '0;
      r.k    = k;
      for (int i = 0; i < RB; i++) begin
         e.chal = c;
         e.idx  = i;
         exp_chal.push_back(e);
         r.data[i] = (($countones(c & puf_mask) % 2) == 1);
         c = ref_next(c);
      end
      exp_resp.push_back(r);
      resp_total++;
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   logic          prev_x  = 1'b0;
   logic          prev_rv = 1'b0;
   logic [CW-1:0] prev_chal = '0;
   logic [RB-1:0] held = '0;
   int            hi_run = 0;
   int            lo_run = 0;
   chal_t         mc;
   resp_t         mr;

   always @(negedge clk) begin
      if (rst) begin
         prev_x  = 1'b0;
         prev_rv = 1'b0;
         hi_run  = 0;
         lo_run  = 0;
      end else begin
         chk("y_equals_x", puf_y, puf_x);
         if (puf_x && prev_x) begin
            checks++;
            a_chal_stable: assert (puf_chal === prev_chal)
               else begin
                  errors++;
                  $display("FAIL chal_stable_during_race: got %0h expected %0h", puf_chal, prev_chal);
               end
         end
         if (puf_x && !prev_x) begin
            if (exp_chal.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_launch: got chal %0h expected no launch", puf_chal);
            end else begin
               mc = exp_chal.pop_front();
               chk("launch_chal", puf_chal, mc.chal);
               if (mc.idx > 0) chk("xy_low_len", lo_run, DC);
            end
            hi_run = 1;
         end else if (puf_x) begin
            hi_run++;
         end else if (prev_x) begin
            chk("xy_high_len", hi_run, ST + 1);
            lo_run = 1;
         end else begin
            lo_run++;
         end

         if (bus.resp_valid) begin
            chk("seed_ready_in_done", bus.seed_ready, 0);
            if (!prev_rv) begin
               if (exp_resp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got %0h expected no response", bus.resp_data);
               end else begin
                  mr = exp_resp.pop_front();
                  chk("resp_data", bus.resp_data, mr.data);
                  chk("resp_latency", cyc, mr.k + 1 + RB * BIT_TIME);
                  resp_seen++;
               end
               held = bus.resp_data;
            end else begin
               chk("resp_hold", bus.resp_data, held);
            end
            if (bus.resp_ready) hs_edge = cyc + 1;
         end else if (prev_rv) begin
            chk("resp_valid_hold", bus.resp_valid, 1);
         end
         prev_rv   = bus.resp_valid && !bus.resp_ready;
         prev_x    = puf_x;
         prev_chal = puf_chal;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic send_seed(input logic [CW-1:0] s, output int k);
      int n;
      n              = 0;
      k              = -1;
      bus.seed_valid = 1'b1;
      bus.seed_chal  = s;
      @(negedge clk);
      while (!bus.seed_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!bus.seed_ready) begin
         checks++;
         errors++;
         $display("FAIL seed_accept_timeout: got seed_ready 0 expected 1 within 400 cycles");
      end else begin
         k = cyc + 1;
         push_model(s, k);
      end
      @(posedge clk);
      #1;
      bus.seed_valid = 1'b0;
      bus.seed_chal  = CW'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_resp.size() != 0 || bus.resp_valid) && n < 400) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_resp.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_seed_ready"}, bus.seed_ready, 0);
      chk({tag, "_resp_valid"}, bus.resp_valid, 0);
      chk({tag, "_resp_data"},  bus.resp_data, 0);
      chk({tag, "_puf_chal"},   puf_chal, 0);
      chk({tag, "_puf_x"},      puf_x, 0);
      chk({tag, "_puf_y"},      puf_y, 0);
   endtask

   initial begin
      int            k;
      int            n;
      logic [CW-1:0] s;
      logic [CW-1:0] s2;

      bus.seed_valid = 1'b0;
      bus.seed_chal  = '0;
      bus.resp_ready = 1'b0;

      // Reset values, then seed_ready rising one cycle after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("seed_ready_at_release", bus.seed_ready, 0);
      @(negedge clk);
      chk("seed_ready_after_release", bus.seed_ready, 1);
      @(posedge clk);
      #1;

      // Fixed seed with full-parity PUF model.
      bus.resp_ready = 1'b1;
      send_seed(22'h2AAAAA, k);
      wait_drain();

      // Zero seed substitutes 1.
      send_seed(22'h000000, k);
      wait_drain();

      // Consumer stalls in DONE while a new seed is offered.
      bus.resp_ready = 1'b0;
      s  = CW'($urandom) | CW'(1);
      s2 = CW'($urandom);
      send_seed(s, k);
      n = 0;
      while (!bus.resp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.resp_valid) begin
         errors++;
         $display("FAIL stall_wait_valid: got resp_valid 0 expected 1");
      end
      @(posedge clk);
      #1;
      bus.seed_valid = 1'b1;
      bus.seed_chal  = s2;
      repeat (10) @(posedge clk);
      #1 bus.resp_ready = 1'b1;
      send_seed(s2, k);
      chk("stall_then_accept", k, hs_edge + 1);
      wait_drain();

      // Reset during the second launch aborts the run.
      s = CW'($urandom);
      send_seed(s, k);
      while (cyc < k + BIT_TIME + 1) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      resp_total -= exp_resp.size();
      exp_resp.delete();
      exp_chal.delete();
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midrun_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      send_seed(CW'($urandom), k);
      wait_drain();

      // Back-to-back random seeds with a random PUF mask.
      puf_mask = CW'($urandom);
      for (int i = 0; i < 20; i++) begin
         s = ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom);
         send_seed(s, k);
         if (i > 0) chk("b2b_accept_cycle", k, hs_edge + 1);
      end
      wait_drain();

      chk("resp_count", resp_seen, resp_total);
      chk("chal_queue_empty", exp_chal.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule : tb_apuf_challenge_sequencer

`default_nettype wire
